fic2_apb_timer_slave: RTL

- Fabric-side APB3 completer that answers the MSS FIC_2 APB master port: PSEL, PENABLE, PWRITE, PADDR and PWDATA in; PRDATA, PREADY and PSLVERR out.
- Provides a 32-bit down-counting timer (control, reload, current value, W1C status) plus a scratch register.
- Inserts a programmable number of wait states and raises PSLVERR on unmapped addresses.
- Lets firmware exercise the full FIC_2 APB path, including wait-state and error responses, with real sequential state behind it.

---
 rtl/fic2_apb_pkg.sv | 48 ++++
 rtl/apb3_wait_fsm.sv | 85 ++++++++
 rtl/fic2_apb_timer_slave.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fic2_apb_pkg.sv
// Shared definitions for FIC_2 APB completers: register offsets, CTRL bit
// positions and the APB transfer FSM state type.
package fic2_apb_pkg;

  localparam int unsigned OFF_CTRL    = 32'h00;
  localparam int unsigned OFF_LOAD    = 32'h04;
  localparam int unsigned OFF_VALUE   = 32'h08;
  localparam int unsigned OFF_STATUS  = 32'h0C;
  localparam int unsigned OFF_SCRATCH = 32'h10;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_IRQ_EN  = 1;
  localparam int unsigned CTRL_ONESHOT = 2;
  localparam int unsigned STATUS_PEND  = 0;

  localparam int unsigned WAIT_CNT_W = 3;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StWait,
    StDone
  } apb_state_e;

  typedef enum logic [2:0] {
    RegCtrl,
    RegLoad,
    RegValue,
    RegStatus,
    RegScratch,
    RegNone
  } reg_sel_e;

  // word_addr is the byte address shifted right by two.
  function automatic reg_sel_e decode_reg(input logic [31:0] word_addr);
    reg_sel_e sel;
    case (word_addr)
      OFF_CTRL >> 2:    sel = RegCtrl;
      OFF_LOAD >> 2:    sel = RegLoad;
      OFF_VALUE >> 2:   sel = RegValue;
      OFF_STATUS >> 2:  sel = RegStatus;
      OFF_SCRATCH >> 2: sel = RegScratch;
      default:          sel = RegNone;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/apb3_wait_fsm.sv
// APB3 completer transfer sequencer: tracks the bus phase, inserts a fixed number
// of wait states and produces the completion (PREADY / commit) strobe.
module apb3_wait_fsm
  import fic2_apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  output logic                  ready,
  output logic                  capture,
  output logic [ADDR_WIDTH-1:0] xfer_addr,
  output logic                  xfer_write
);

  localparam logic [WAIT_CNT_W-1:0] WaitLoad = WAIT_CNT_W'(WAIT_STATES);
  localparam logic [WAIT_CNT_W-1:0] WaitLast = WAIT_CNT_W'(1);

  apb_state_e state, state_next, phase;
  logic [WAIT_CNT_W-1:0] wait_cnt, wait_cnt_next;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic                  lat_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      wait_cnt  <= '0;
      lat_addr  <= '0;
      lat_write <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (phase == StSetup) begin
        lat_addr  <= paddr;
        lat_write <= pwrite;
      end
    end
  end

  // The APB setup cycle is seen combinationally from IDLE, so a back-to-back
  // setup right after DONE is handled without a dead cycle.
  always_comb begin
    phase = state;
    if (state == StIdle && psel && !penable) begin
      phase = StSetup;
    end
  end

  always_comb begin
    state_next    = phase;
    wait_cnt_next = wait_cnt;
    unique case (phase)
      StIdle: state_next = StIdle;
      StSetup: begin
        wait_cnt_next = WaitLoad;
        state_next    = (WAIT_STATES > 0) ? StWait : StDone;
      end
      StWait: begin
        if (!psel) begin
          state_next = StIdle;
        end else if (penable) begin
          wait_cnt_next = wait_cnt - 1'b1;
          if (wait_cnt == WaitLast) begin
            state_next = StDone;
          end
        end
      end
      StDone:  state_next = StIdle;
      default: state_next = StIdle;
    endcase
  end

  always_comb begin
    ready      = (state == StDone) && psel && penable;
    capture    = (state_next == StDone);
    xfer_addr  = (phase == StSetup) ? paddr : lat_addr;
    xfer_write = (phase == StSetup) ? pwrite : lat_write;
  end

endmodule

// File: rtl/fic2_apb_timer_slave.sv
// FIC_2 APB3 completer with a 32-bit down-counting timer (CTRL, LOAD, VALUE,
// W1C STATUS), a scratch register, programmable wait states and PSLVERR decode.
module fic2_apb_timer_slave
  import fic2_apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_STATES = 1,
  parameter bit          ONESHOT_DEF = 1'b0
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]           PWDATA,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  TIMER_IRQ
);

  logic                  ready, capture, xfer_write;
  logic [ADDR_WIDTH-1:0] xfer_addr;
  reg_sel_e              reg_sel;

  apb3_wait_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WAIT_STATES(WAIT_STATES)
  ) u_fsm (
    .clk       (PCLK),
    .rst_n     (PRESETN),
    .psel      (PSEL),
    .penable   (PENABLE),
    .pwrite    (PWRITE),
    .paddr     (PADDR),
    .ready     (ready),
    .capture   (capture),
    .xfer_addr (xfer_addr),
    .xfer_write(xfer_write)
  );

  assign reg_sel = decode_reg(32'(xfer_addr >> 2));

  logic        en, irq_en, oneshot, pend;
  logic        en_next, irq_en_next, oneshot_next, pend_next;
  logic [31:0] load_val, value, scratch;
  logic [31:0] load_next, value_next, scratch_next;
  logic        err_resp;
  logic [31:0] rdata_mux;
  logic        commit, wr_ctrl, wr_load, wr_status, wr_scratch, expire;

  assign commit     = ready && xfer_write;
  assign wr_ctrl    = commit && (reg_sel == RegCtrl);
  assign wr_load    = commit && (reg_sel == RegLoad);
  assign wr_status  = commit && (reg_sel == RegStatus);
  assign wr_scratch = commit && (reg_sel == RegScratch);
  assign expire     = en && (value == 32'd0);

  // Timer step first, then bus writes override it (LOAD wins for VALUE, CTRL
  // wins for EN); a same-edge expiry keeps PEND set against a W1C.
  always_comb begin
    en_next      = en;
    irq_en_next  = irq_en;
    oneshot_next = oneshot;
    pend_next    = pend;
    load_next    = load_val;
    value_next   = value;
    scratch_next = scratch;
    if (en) begin
      if (value != 32'd0) begin
        value_next = value - 32'd1;
      end else begin
        pend_next = 1'b1;
        if (oneshot) begin
          en_next = 1'b0;
        end else begin
          value_next = load_val;
        end
      end
    end
    if (wr_ctrl) begin
      en_next      = PWDATA[CTRL_EN];
      irq_en_next  = PWDATA[CTRL_IRQ_EN];
      oneshot_next = PWDATA[CTRL_ONESHOT];
    end
    if (wr_load) begin
      load_next  = PWDATA;
      value_next = PWDATA;
    end
    if (wr_status && PWDATA[STATUS_PEND] && !expire) begin
      pend_next = 1'b0;
    end
    if (wr_scratch) begin
      scratch_next = PWDATA;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      en       <= 1'b0;
      irq_en   <= 1'b0;
      oneshot  <= ONESHOT_DEF;
      pend     <= 1'b0;
      load_val <= 32'd0;
      value    <= 32'd0;
      scratch  <= 32'd0;
    end else begin
      en       <= en_next;
      irq_en   <= irq_en_next;
      oneshot  <= oneshot_next;
      pend     <= pend_next;
      load_val <= load_next;
      value    <= value_next;
      scratch  <= scratch_next;
    end
  end

  always_comb begin
    rdata_mux = 32'd0;
    unique case (reg_sel)
      RegCtrl: begin
        rdata_mux[CTRL_EN]      = en;
        rdata_mux[CTRL_IRQ_EN]  = irq_en;
        rdata_mux[CTRL_ONESHOT] = oneshot;
      end
      RegLoad:    rdata_mux = load_val;
      RegValue:   rdata_mux = value;
      RegStatus:  rdata_mux[STATUS_PEND] = pend;
      RegScratch: rdata_mux = scratch;
      default:    rdata_mux = 32'd0;
    endcase
  end

  // Response is captured on the edge entering DONE; write transfers to mapped
  // registers leave PRDATA holding its previous value.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      PRDATA   <= 32'd0;
      err_resp <= 1'b0;
    end else if (capture) begin
      err_resp <= (reg_sel == RegNone);
      if (reg_sel == RegNone) begin
        PRDATA <= 32'd0;
      end else if (!xfer_write) begin
        PRDATA <= rdata_mux;
      end
    end else begin
      err_resp <= 1'b0;
    end
  end

  assign PREADY    = ready;
  assign PSLVERR   = err_resp && ready;
  assign TIMER_IRQ = pend && irq_en;

endmodule
